seq_sel_ctrl: RTL and testbench
===============================

SEQ_SEL_CTRL -- requirements
Module: seq_sel_ctrl

Interface
REQ-001 SHALL have port: clk_sys  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: req_valid  in  1  host request strobe to switch the active pulse sequencer.
REQ-004 SHALL have port: req_sel  in  2  requested sequencer (00=seq1, 01=seq2, 10=seq3, 11=illegal).
REQ-005 SHALL have port: guard_cycles  in  8  guard interval length in clk_sys cycles.
REQ-006 SHALL have port: busy  in  3  per-sequencer busy; bit0=seq1, bit1=seq2, bit2=seq3.
REQ-007 SHALL have port: change  out  2  source select to the downstream control mux; 11 = park/hold.
REQ-008 SHALL have port: seq_en  out  3  one-hot enable to the selected sequencer; 000 while switching.
REQ-009 SHALL have port: req_ready  out  1  high when a request can be accepted.
REQ-010 SHALL have port: sw_done  out  1  one-cycle pulse when a new selection commits.
REQ-011 SHALL have port: req_err  out  1  one-cycle pulse on an accepted illegal req_sel.
REQ-012 SHALL have port: drain_to  out  1  one-cycle pulse when the drain timeout forces a switch.

Function
REQ-013 SHALL register all outputs; accept = req_valid & req_ready at cycle T0.
REQ-014 SHALL have states IDLE, DRAIN, GUARD, COMMIT; req_ready=1 only in IDLE.
REQ-015 SHALL, on accept with req_sel=11, stay IDLE, assert req_err at T0+1 and leave change/seq_en unchanged.
REQ-016 SHALL, on accept with req_sel equal to current change, stay IDLE and pulse sw_done at T0+1, with no guard and no change toggle.
REQ-017 SHALL, on any other accept, latch req_sel and guard_cycles, enter DRAIN at T0+1, and drive seq_en=000.
REQ-018 SHALL, in DRAIN, sample busy[current change]; when 0, enter GUARD next cycle.
REQ-019 SHALL, in DRAIN, count cycles with a 16-bit counter; at 65535 cycles, enter GUARD and pulse drain_to on GUARD entry.
REQ-020 SHALL drive change=11 throughout GUARD, so the downstream mux holds its last outputs.
REQ-021 SHALL stay in GUARD for max(latched guard_cycles,1) cycles; guard_cycles=0 gives 1 cycle.
REQ-022 SHALL, in COMMIT (1 cycle), drive change=latched sel and seq_en=one-hot(sel), pulse sw_done, then return to IDLE.
REQ-023 SHALL ignore req_valid while req_ready=0; there is no queueing and no error flag for it.
REQ-024 SHALL ignore busy bits of non-current sequencers.
REQ-025 SHALL ignore changes to guard_cycles after accept.
REQ-026 SHALL never drive change=11 outside GUARD; seq_en SHALL always be 000 or one-hot.

Reset
REQ-027 SHALL, on rst_n=0 at a clock edge, set state=IDLE, change=00, seq_en=001, req_ready=1, sw_done=0, req_err=0, drain_to=0, and clear counters.
REQ-028 SHALL abort any in-progress switch immediately on reset, from any state, returning to seq1 selection.

Structure
REQ-029 SHALL place the state enum, SEL_PARK=2'b11 and DRAIN_TIMEOUT=16'hFFFF in shared package seq_sel_pkg.
REQ-030 SHALL use one sub-module, seq_sel_timer: a loadable 16-bit down-counter with zero flag, shared by DRAIN and GUARD.

Verification
REQ-031 SHALL cover: reset, then req_sel=01, guard=4, busy=000 at T0 -> seq_en=000 at T1; change=11 at T2..T5; change=01, seq_en=010 and sw_done at T6; req_ready at T7.
REQ-032 SHALL cover: current=00 with busy[0]=1 for 10 cycles, then req_sel=10, guard=0 -> DRAIN held until busy[0] falls; change=11 for 1 cycle; then change=10.
REQ-033 SHALL cover: busy[0] held at 1 forever, req_sel=01 -> GUARD entered after 65535 DRAIN cycles; drain_to pulses once; commit to 01.
REQ-034 SHALL cover: req_sel=11 -> req_err pulse at T0+1; change/seq_en unchanged; req_ready stays 1.
REQ-035 SHALL cover: req_sel equal to current -> sw_done at T0+1; change never 11.
REQ-036 SHALL cover: rst_n=0 during GUARD -> next cycle change=00, seq_en=001, req_ready=1; a req_valid pulsed during DRAIN is ignored.

Source files
------------

// File: rtl/seq_sel_pkg.sv
// Shared types and constants for the pulse-sequencer select controller.
package seq_sel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    GUARD  = 2'd2,
    COMMIT = 2'd3
  } state_e;

  localparam logic [1:0]  SEL_PARK      = 2'b11;
  localparam logic [15:0] DRAIN_TIMEOUT = 16'hFFFF;

  function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
    logic [2:0] oh;
    case (sel)
      2'b00:   oh = 3'b001;
      2'b01:   oh = 3'b010;
      2'b10:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  function automatic logic sel_busy(input logic [2:0] busy, input logic [1:0] sel);
    logic b;
    case (sel)
      2'b00:   b = busy[0];
      2'b01:   b = busy[1];
      2'b10:   b = busy[2];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/seq_sel_timer.sv
// Loadable 16-bit down-counter with zero flag; shared by the drain timeout and guard interval.
module seq_sel_timer (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  output logic        zero_o
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != 16'd0) begin
      count_d = count_q - 16'd1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 16'd0);

endmodule

// File: rtl/seq_sel_ctrl.sv
// Break-before-make switch between three pulse sequencers: drain the current one,
// park the downstream mux for a guard interval, then commit the new selection.
//
// state  | meaning
// IDLE   | selection stable, requests accepted
// DRAIN  | new selection latched, waiting for current sequencer to go idle (or timeout)
// GUARD  | mux parked (change=11) for max(guard,1) cycles
// COMMIT | one cycle driving the new selection and pulsing sw_done
module seq_sel_ctrl
  import seq_sel_pkg::*;
(
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  input  logic [7:0] guard_cycles,
  input  logic [2:0] busy,
  output logic [1:0] change,
  output logic [2:0] seq_en,
  output logic       req_ready,
  output logic       sw_done,
  output logic       req_err,
  output logic       drain_to
);

  state_e      state_q, state_d;
  logic [1:0]  cur_sel_q, cur_sel_d;
  logic [1:0]  new_sel_q, new_sel_d;
  logic [7:0]  guard_q, guard_d;
  logic [1:0]  change_q, change_d;
  logic [2:0]  seq_en_q, seq_en_d;
  logic        req_ready_q, req_ready_d;
  logic        sw_done_q, sw_done_d;
  logic        req_err_q, req_err_d;
  logic        drain_to_q, drain_to_d;

  logic        accept;
  logic        busy_cur;
  logic        tmr_load;
  logic [15:0] tmr_val;
  logic        tmr_zero;
  logic [7:0]  guard_len;

  assign accept    = req_valid & req_ready_q;
  assign busy_cur  = sel_busy(busy, cur_sel_q);
  assign guard_len = (guard_q == 8'd0) ? 8'd1 : guard_q;

  seq_sel_timer u_timer (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_sel_q   <= 2'b00;
      new_sel_q   <= 2'b00;
      guard_q     <= 8'd0;
      change_q    <= 2'b00;
      seq_en_q    <= 3'b001;
      req_ready_q <= 1'b1;
      sw_done_q   <= 1'b0;
      req_err_q   <= 1'b0;
      drain_to_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      new_sel_q   <= new_sel_d;
      guard_q     <= guard_d;
      change_q    <= change_d;
      seq_en_q    <= seq_en_d;
      req_ready_q <= req_ready_d;
      sw_done_q   <= sw_done_d;
      req_err_q   <= req_err_d;
      drain_to_q  <= drain_to_d;
    end
  end

  // Timer is reloaded on each phase entry, so DRAIN and GUARD can share it.
  always_comb begin
    state_d   = state_q;
    new_sel_d = new_sel_q;
    guard_d   = guard_q;
    tmr_load  = 1'b0;
    tmr_val   = 16'd0;
    case (state_q)
      IDLE: begin
        if (accept && req_sel != SEL_PARK && req_sel != cur_sel_q) begin
          state_d   = DRAIN;
          new_sel_d = req_sel;
          guard_d   = guard_cycles;
          tmr_load  = 1'b1;
          tmr_val   = DRAIN_TIMEOUT - 16'd1;
        end
      end
      DRAIN: begin
        if (!busy_cur || tmr_zero) begin
          state_d  = GUARD;
          tmr_load = 1'b1;
          tmr_val  = {8'h00, guard_len - 8'd1};
        end
      end
      GUARD: begin
        if (tmr_zero) state_d = COMMIT;
      end
      COMMIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_sel_d   = (state_d == COMMIT) ? new_sel_q : cur_sel_q;
    change_d    = cur_sel_q;
    seq_en_d    = 3'b000;
    req_ready_d = (state_d == IDLE);
    sw_done_d   = (state_d == COMMIT) || (accept && req_sel == cur_sel_q);
    req_err_d   = accept && (req_sel == SEL_PARK);
    drain_to_d  = (state_q == DRAIN) && (state_d == GUARD) && busy_cur;
    case (state_d)
      IDLE:    seq_en_d = sel_onehot(cur_sel_q);
      GUARD:   change_d = SEL_PARK;
      COMMIT: begin
        change_d = new_sel_q;
        seq_en_d = sel_onehot(new_sel_q);
      end
      default: seq_en_d = 3'b000;
    endcase
  end

  assign change    = change_q;
  assign seq_en    = seq_en_q;
  assign req_ready = req_ready_q;
  assign sw_done   = sw_done_q;
  assign req_err   = req_err_q;
  assign drain_to  = drain_to_q;

endmodule

// File: tb/tb_seq_sel_ctrl.sv
// Bench for seq_sel_ctrl: directed scenarios plus random switch requests checked
// against a per-request timeline model (drain length, guard length, commit).
module tb_seq_sel_ctrl;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_sel;
  logic [7:0] guard_cycles;
  logic [2:0] busy;
  logic [1:0] change;
  logic [2:0] seq_en;
  logic       req_ready;
  logic       sw_done;
  logic       req_err;
  logic       drain_to;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [1:0] cur;

  seq_sel_ctrl dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_sel      (req_sel),
    .guard_cycles (guard_cycles),
    .busy         (busy),
    .change       (change),
    .seq_en       (seq_en),
    .req_ready    (req_ready),
    .sw_done      (sw_done),
    .req_err      (req_err),
    .drain_to     (drain_to)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [2:0] oh(input logic [1:0] s);
    case (s)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Packed as {change, seq_en, req_ready, sw_done, req_err, drain_to}.
  function automatic logic [8:0] pk(input logic [1:0] c, input logic [2:0] e,
                                    input logic r, input logic d, input logic er, input logic dt);
    return {c, e, r, d, er, dt};
  endfunction

  function automatic logic [2:0] busy_with(input logic [1:0] c, input logic b);
    logic [2:0] v;
    v = 3'($urandom);
    v[c] = b;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {change, seq_en, req_ready, sw_done, req_err, drain_to};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed(chg,en,rdy,done,err,dto)=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One host request from IDLE. busy[cur] stays high for the first `hold` drain cycles.
  task automatic run_req(input logic [1:0] sel, input int g, input int hold, input bit abort_guard);
    int d;
    int n;
    bit to;
    chk("idle_pre", pk(cur, oh(cur), 1, 0, 0, 0));
    req_valid    = 1'b1;
    req_sel      = sel;
    guard_cycles = 8'(g);
    busy         = busy_with(cur, 1'($urandom_range(0, 1)));
    step();
    req_valid    = 1'b0;
    guard_cycles = 8'($urandom);
    if (sel == 2'd3) begin
      chk("illegal_err", pk(cur, oh(cur), 1, 0, 1, 0));
      step();
      chk("illegal_after", pk(cur, oh(cur), 1, 0, 0, 0));
      return;
    end
    if (sel == cur) begin
      chk("same_sel_done", pk(cur, oh(cur), 1, 1, 0, 0));
      step();
      chk("same_sel_after", pk(cur, oh(cur), 1, 0, 0, 0));
      return;
    end
    to = (hold >= 65535);
    d  = to ? 65535 : hold + 1;
    n  = (g == 0) ? 1 : g;
    for (int k = 1; k <= d; k++) begin
      busy      = busy_with(cur, (k <= hold) ? 1'b1 : 1'b0);
      req_valid = (k == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      req_sel   = 2'($urandom);
      chk("drain", pk(cur, 3'b000, 0, 0, 0, 0));
      step();
    end
    for (int j = 1; j <= n; j++) begin
      busy      = 3'($urandom);
      req_valid = 1'($urandom_range(0, 1));
      req_sel   = 2'($urandom);
      chk("guard", pk(2'b11, 3'b000, 0, 0, 0, (j == 1) && to));
      if (abort_guard) begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        step();
        rst_n = 1'b1;
        chk("reset_abort", pk(2'b00, 3'b001, 1, 0, 0, 0));
        cur = 2'd0;
        return;
      end
      step();
    end
    req_valid = 1'b0;
    chk("commit", pk(sel, oh(sel), 0, 1, 0, 0));
    step();
    cur = sel;
    chk("idle_post", pk(cur, oh(cur), 1, 0, 0, 0));
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_sel      = 2'd0;
    guard_cycles = 8'd0;
    busy         = 3'b000;
    cur          = 2'd0;
    step();
    step();
    chk("reset", pk(2'b00, 3'b001, 1, 0, 0, 0));
    rst_n = 1'b1;
    step();
    chk("reset_release", pk(2'b00, 3'b001, 1, 0, 0, 0));

    run_req(2'd1, 4, 0, 1'b0);       // basic switch to seq2, 4-cycle guard
    run_req(2'd0, 1, 0, 1'b0);
    run_req(2'd2, 0, 10, 1'b0);      // drain held by busy, zero guard
    run_req(2'd0, 2, 0, 1'b0);
    run_req(2'd1, 3, 65535, 1'b0);   // drain timeout
    run_req(2'd3, 5, 0, 1'b0);       // illegal select
    run_req(2'd1, 7, 0, 1'b0);       // same as current
    run_req(2'd2, 3, 2, 1'b1);       // reset during guard

    for (int t = 0; t < 40; t++) begin
      run_req(2'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 12)), ($urandom_range(0, 9) == 0));
      repeat ($urandom_range(0, 2)) begin
        busy = 3'($urandom);
        step();
        chk("idle_gap", pk(cur, oh(cur), 1, 0, 0, 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
